// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with stall, redirect and circular return-address stack
// Optional feature macro: PC_ALIGN_CHECK_EN (forces redirect targets to STEP alignment, pulses misalign)
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h00001000),
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             resetPC,
    input  logic                             stall,
    input  logic                             branch_taken,
    input  logic [WIDTH-1:0]                 branch_target,
    input  logic                             call,
    input  logic                             ret,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow,
    output logic                             misalign
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr, ptr_pop, ptr_nxt;
    logic [CW-1:0]    cnt_pop, cnt_nxt;
    logic [WIDTH-1:0] link, target, pc_nxt;
    logic             do_pop, redirect, full_push, mis_nxt;

    // ptr is the next free slot; the top of stack lives at ptr-1
    always_comb begin
        link      = pc + WIDTH'(STEP);
        do_pop    = ret && (ras_count != '0);
        redirect  = do_pop || branch_taken;
        target    = do_pop ? ras_mem[ptr - PW'(1)] : branch_target;
`ifdef PC_ALIGN_CHECK_EN
        mis_nxt   = redirect && (|(target & WIDTH'(STEP - 1)));
        pc_nxt    = redirect ? (target & ~WIDTH'(STEP - 1)) : link;
`else
        mis_nxt   = 1'b0;
        pc_nxt    = redirect ? target : link;
`endif
        ptr_pop   = do_pop ? ptr - PW'(1) : ptr;
        cnt_pop   = do_pop ? ras_count - CW'(1) : ras_count;
        // a push into a full stack lands on the oldest entry, which is exactly ptr_pop
        full_push = call && (cnt_pop == CW'(RAS_DEPTH));
        ptr_nxt   = call ? ptr_pop + PW'(1) : ptr_pop;
        cnt_nxt   = (call && !full_push) ? cnt_pop + CW'(1) : cnt_pop;
    end

    always_ff @(posedge clk) begin
        if (resetPC) begin
            pc            <= RESET_VEC;
            ptr           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (stall) begin
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            ptr           <= ptr_nxt;
            ras_count     <= cnt_nxt;
            ras_underflow <= ret && (ras_count == '0);
            if (full_push)
                ras_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetPC && !stall && call)
            ras_mem[ptr_pop] <= link;
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (resetPC || stall)
            misalign <= 1'b0;
        else
            misalign <= mis_nxt;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        resetPC, stall, branch_taken, call, ret;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow, misalign;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q [$];
    logic        m_ovf, m_unf, m_mis;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .resetPC(resetPC), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .call(call), .ret(ret), .pc(pc),
        .ras_count(ras_count), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic cyc(input logic rst, input logic st, input logic br,
                       input logic [31:0] tgt, input logic cl, input logic rt);
        logic [31:0] link, t;
        logic        redir;
        resetPC = rst; stall = st; branch_taken = br; branch_target = tgt; call = cl; ret = rt;
        m_unf = 1'b0;
        m_mis = 1'b0;
        if (rst) begin
            m_pc  = 32'h0000_1000;
            m_q.delete();
            m_ovf = 1'b0;
        end else if (!st) begin
            link  = m_pc + 32'd4;
            m_unf = rt && (m_q.size() == 0);
            redir = 1'b1;
            if (rt && m_q.size() > 0) t = m_q.pop_back();
            else if (br)              t = tgt;
            else begin t = link; redir = 1'b0; end
`ifdef PC_ALIGN_CHECK_EN
            if (redir && (t % 4 != 0)) begin
                t     = t - (t % 4);
                m_mis = 1'b1;
            end
`endif
            m_pc = t;
            if (cl) begin
                m_q.push_back(link);
                if (m_q.size() > 4) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("ras_count", 32'(ras_count), 32'(m_q.size()));
        check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
        check("misalign", 32'(misalign), 32'(m_mis));
    endtask

    initial begin
        logic [31:0] tgt;
        resetPC = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; call = 1'b0; ret = 1'b0;
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
        @(negedge clk);

        // reset then sequential stepping
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h0000_1000);
        check("reset_cnt", 32'(ras_count), 0);
        cyc(0, 0, 0, 0, 0, 0); check("seq1", pc, 32'h0000_1004);
        cyc(0, 0, 0, 0, 0, 0); check("seq2", pc, 32'h0000_1008);
        cyc(0, 0, 0, 0, 0, 0); check("seq3", pc, 32'h0000_100C);

        // stall overrides branch
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h3000, 0, 0); check("stall1", pc, 32'h0000_1008);
        cyc(0, 1, 1, 32'h3000, 1, 1); check("stall2", pc, 32'h0000_1008);
        cyc(0, 0, 0, 0, 0, 0);        check("stall_rel", pc, 32'h0000_100C);

        // call then return
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h2000, 1, 0); check("call_pc", pc, 32'h0000_2000);
        check("call_cnt", 32'(ras_count), 1);
        cyc(0, 0, 0, 0, 0, 1);        check("ret_pc", pc, 32'h0000_1004);
        check("ret_cnt", 32'(ras_count), 0);

        // overflow: five nested calls, four returns, then an underflowing return
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h4000 + 32'(i) * 32'h100, 1, 0);
        check("ovf_cnt", 32'(ras_count), 4);
        check("ovf_flag", 32'(ras_overflow), 1);
        cyc(0, 0, 0, 0, 0, 1); check("pop5", pc, 32'h0000_4304);
        cyc(0, 0, 0, 0, 0, 1); check("pop4", pc, 32'h0000_4204);
        cyc(0, 0, 0, 0, 0, 1); check("pop3", pc, 32'h0000_4104);
        cyc(0, 0, 0, 0, 0, 1); check("pop2", pc, 32'h0000_4004);
        cyc(0, 0, 0, 0, 0, 1); check("unf_pc", pc, 32'h0000_4008);
        check("unf_pulse", 32'(ras_underflow), 1);
        cyc(0, 0, 0, 0, 0, 0); check("unf_clear", 32'(ras_underflow), 0);
        check("ovf_sticky", 32'(ras_overflow), 1);

        // call+ret together: non-empty and empty stack
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h5000, 1, 0);
        cyc(0, 0, 1, 32'h6000, 1, 1); check("cr_pc", pc, 32'h0000_1004);
        check("cr_cnt", 32'(ras_count), 1);
        cyc(0, 0, 0, 0, 0, 1);        check("cr_pop", pc, 32'h0000_5004);
        cyc(0, 0, 1, 32'h7000, 1, 1); check("cre_unf", 32'(ras_underflow), 1);
        check("cre_cnt", 32'(ras_count), 1);

        // wrap and reset priority
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);        check("wrap", pc, 32'h0000_0000);
        cyc(1, 1, 0, 0, 0, 1);        check("rst_prio", pc, 32'h0000_1000);
        check("rst_prio_cnt", 32'(ras_count), 0);

        // misaligned branch target
        cyc(0, 0, 1, 32'h2002, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc", pc, 32'h0000_2000);
        check("mis_flag", 32'(misalign), 1);
`else
        check("mis_pc", pc, 32'h0000_2002);
        check("mis_flag", 32'(misalign), 0);
`endif

        // randomized traffic against the model
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt = tgt & 32'hFFFF_FFFC;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0, tgt,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
